hit_resolver: RTL and testbench

Downstream consumer of the collision detector's player_1_collision/player_2_collision flags. It combines those flags with each player's attack button to run the per-player attack state machines. It applies damage with invulnerability windows, tracks health, and declares KO/winner. Its outputs drive the health-bar renderer and the round-control logic.

---
 rtl/hit_resolver.sv | 192 +++++++++++++++++++
 tb/tb_hit_resolver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// hit_resolver: turns collision flags and attack buttons into damage.
// Runs one attack FSM per player, applies hits with invulnerability
// windows, tracks health and declares the round result (KO / winner).
// Player index 0 is P1 and index 1 is P2 throughout.
module hit_resolver #(
    parameter int MAX_HEALTH     = 100,
    parameter int DAMAGE         = 10,
    parameter int TICK_DIV       = 5000000,
    parameter int ATTACK_TICKS   = 3,
    parameter int COOLDOWN_TICKS = 4,
    parameter int INVULN_TICKS   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       player_1_collision,
    input  logic       player_2_collision,
    input  logic       p1_attack,
    input  logic       p2_attack,
    input  logic       restart,
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_attacking,
    output logic       p2_attacking,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    localparam int             TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [6:0]     HEALTH_INIT = 7'(MAX_HEALTH);
    localparam logic [7:0]     DAMAGE_W    = 8'(DAMAGE);
    localparam logic [7:0]     ATTACK_LOAD = 8'(ATTACK_TICKS);
    localparam logic [7:0]     COOL_LOAD   = 8'(COOLDOWN_TICKS);
    localparam logic [7:0]     INVULN_LOAD = 8'(INVULN_TICKS);

    logic          coll_meta;
    logic          coll_sync;
    logic [1:0]    att_q;
    logic [1:0]    rise;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          restart_go;

    logic [1:0]    state   [2];
    logic [7:0]    win_cnt [2];
    logic [7:0]    inv_cnt [2];
    logic [6:0]    health  [2];
    logic [1:0]    landed;
    logic [1:0]    strike;   // strike[i]: player i lands a hit this cycle
    logic [1:0]    struck;   // struck[i]: player i takes a hit this cycle
    logic [1:0]    hit;

    // Saturating damage; the 8-bit compare keeps health < DAMAGE from wrapping.
    function automatic logic [6:0] take_damage(input logic [6:0] h);
        if ({1'b0, h} < DAMAGE_W)
            return 7'd0;
        return h - DAMAGE_W[6:0];
    endfunction

    assign rise       = {p2_attack, p1_attack} & ~att_q;
    assign tick       = (tick_cnt == TICK_LAST);
    assign restart_go = restart & game_over;

    // Hit rule: swinging, not yet landed, touching, defender vulnerable, round live.
    always_comb begin
        strike    = 2'b00;
        strike[0] = (state[0] == S_ACTIVE) && !landed[0] && coll_sync &&
                    (inv_cnt[1] == 8'd0) && !game_over;
        strike[1] = (state[1] == S_ACTIVE) && !landed[1] && coll_sync &&
                    (inv_cnt[0] == 8'd0) && !game_over;
        struck    = {strike[0], strike[1]};
    end

    // Collision 2-FF synchroniser and attack-button edge-detect flops.
    always_ff @(posedge clk) begin
        // NOTE: every clocked block uses non-blocking assignments so all
        // registers update from pre-edge values, matching real flops.
        if (reset) begin
            coll_meta <= 1'b0;
            coll_sync <= 1'b0;
            att_q     <= 2'b00;
        end else begin
            coll_meta <= player_1_collision | player_2_collision;
            coll_sync <= coll_meta;
            att_q     <= {p2_attack, p1_attack};
        end
    end

    // Free-running game-tick divider; a new round restarts the tick phase.
    always_ff @(posedge clk) begin
        if (reset || restart_go || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Per-player attack FSM: IDLE -> ACTIVE -> COOLDOWN -> IDLE, one hit per swing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || game_over) begin
                state[i]   <= S_IDLE;
                win_cnt[i] <= 8'd0;
                landed[i]  <= 1'b0;
            end else begin
                if (strike[i])
                    landed[i] <= 1'b1;
                case (state[i])
                    S_IDLE: begin
                        if (rise[i]) begin
                            state[i]   <= S_ACTIVE;
                            win_cnt[i] <= ATTACK_LOAD;
                            landed[i]  <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        if (tick) begin
                            if (win_cnt[i] <= 8'd1) begin
                                state[i]   <= S_COOLDOWN;
                                win_cnt[i] <= COOL_LOAD;
                            end else begin
                                win_cnt[i] <= win_cnt[i] - 8'd1;
                            end
                        end
                    end
                    S_COOLDOWN: begin
                        if (tick) begin
                            if (win_cnt[i] <= 8'd1) begin
                                state[i]   <= S_IDLE;
                                win_cnt[i] <= 8'd0;
                            end else begin
                                win_cnt[i] <= win_cnt[i] - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state[i]   <= S_IDLE;
                        win_cnt[i] <= 8'd0;
                    end
                endcase
            end
        end
    end

    // Damage, invulnerability windows and one-cycle hit pulses per defender.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset || restart_go) begin
                health[d]  <= HEALTH_INIT;
                inv_cnt[d] <= 8'd0;
                hit[d]     <= 1'b0;
            end else begin
                hit[d] <= struck[d];
                if (struck[d]) begin
                    health[d]  <= take_damage(health[d]);
                    inv_cnt[d] <= INVULN_LOAD;
                end else if (tick && (inv_cnt[d] != 8'd0)) begin
                    inv_cnt[d] <= inv_cnt[d] - 8'd1;
                end
            end
        end
    end

    // Round control: KO one cycle after a health reaches 0; restart only when over.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (game_over) begin
            if (restart) begin
                game_over <= 1'b0;
                winner    <= 2'b00;
            end
        end else if ((health[0] == 7'd0) || (health[1] == 7'd0)) begin
            game_over <= 1'b1;
            winner    <= {health[0] == 7'd0, health[1] == 7'd0};
        end
    end

    assign p1_health    = health[0];
    assign p2_health    = health[1];
    assign p1_attacking = (state[0] == S_ACTIVE);
    assign p2_attacking = (state[1] == S_ACTIVE);
    assign p1_hit       = hit[0];
    assign p2_hit       = hit[1];

endmodule

// File: tb/tb_hit_resolver.sv
// Directed self-checking bench for hit_resolver with a hit-event scoreboard.
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       player_1_collision;
    logic       player_2_collision;
    logic       p1_attack;
    logic       p2_attack;
    logic       restart;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic       p1_attacking;
    logic       p2_attacking;
    logic       p1_hit;
    logic       p2_hit;
    logic       game_over;
    logic [1:0] winner;

    typedef struct packed {
        logic       p1_hit;
        logic       p2_hit;
        logic [6:0] p1_h;
        logic [6:0] p2_h;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    hit_resolver #(
        .MAX_HEALTH     (100),
        .DAMAGE         (10),
        .TICK_DIV       (4),
        .ATTACK_TICKS   (3),
        .COOLDOWN_TICKS (1),
        .INVULN_TICKS   (6)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .player_1_collision (player_1_collision),
        .player_2_collision (player_2_collision),
        .p1_attack          (p1_attack),
        .p2_attack          (p2_attack),
        .restart            (restart),
        .p1_health          (p1_health),
        .p2_health          (p2_health),
        .p1_attacking       (p1_attacking),
        .p2_attacking       (p2_attacking),
        .p1_hit             (p1_hit),
        .p2_hit             (p2_hit),
        .game_over          (game_over),
        .winner             (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, hit pulses scored.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (p1_hit || p2_hit) begin
            if (sb.size() == 0) begin
                check("unexpected_hit", {30'd0, p1_hit, p2_hit}, 0);
            end else begin
                e = sb.pop_front();
                check("sb_p1_hit", p1_hit, e.p1_hit);
                check("sb_p2_hit", p2_hit, e.p2_hit);
                check("sb_p1_health", p1_health, e.p1_h);
                check("sb_p2_health", p2_health, e.p2_h);
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input logic h1, input logic h2, input int e1, input int e2);
        exp_t e;
        e.p1_hit = h1;
        e.p2_hit = h2;
        e.p1_h   = 7'(e1);
        e.p2_h   = 7'(e2);
        sb.push_back(e);
    endtask

    task automatic wait_sb_empty(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic press(input logic a1, input logic a2);
        p1_attack = a1;
        p2_attack = a2;
        cycles(2);
        p1_attack = 1'b0;
        p2_attack = 1'b0;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        player_1_collision = 1'b0;
        player_2_collision = 1'b0;
        p1_attack          = 1'b0;
        p2_attack          = 1'b0;
        restart            = 1'b0;
        sb.delete();
        cycles(2);
        reset = 1'b0;
        cycle();
    endtask

    task automatic check_fresh(input string tag);
        check({tag, "_p1_health"}, p1_health, 100);
        check({tag, "_p2_health"}, p2_health, 100);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_winner"}, winner, 0);
        check({tag, "_attacking"}, {p1_attacking, p2_attacking}, 0);
        check({tag, "_hits"}, {p1_hit, p2_hit}, 0);
    endtask

    initial begin
        int first;
        int pulses;
        bool_loop: begin end

        // Reset state and a quiet idle period.
        do_reset();
        check_fresh("reset");
        cycles(50);
        check_fresh("idle50");

        // Single P1 hit with collision already synchronised.
        player_1_collision = 1'b1;
        cycles(3);
        push(0, 1, 100, 90);
        p1_attack = 1'b1;
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (p2_hit) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 2) p1_attack = 1'b0;
        end
        check("first_hit_pulses", pulses, 1);
        check("first_hit_within_3clk", (first >= 1 && first <= 3), 1);
        check("still_active", p1_attacking, 1);
        for (int k = 0; k < 30; k++) begin
            if (!p1_attacking) break;
            cycle();
        end
        check("active_ended", p1_attacking, 0);
        check("one_hit_per_swing_p2", p2_health, 90);
        check("one_hit_per_swing_p1", p1_health, 100);

        // Second swing while P2 is still invulnerable: no damage.
        for (int t = 0; t < 10; t++) begin
            p1_attack = 1'b1;
            cycle();
            if (p1_attacking) break;
            p1_attack = 1'b0;
            cycle();
        end
        player_1_collision = 1'b0;
        p1_attack = 1'b0;
        check("second_swing_started", p1_attacking, 1);
        cycles(20);
        check("invuln_blocks_p2", p2_health, 90);

        // Swing after invulnerability has expired lands again.
        cycles(45);
        player_1_collision = 1'b1;
        cycles(3);
        push(0, 1, 100, 80);
        press(1, 0);
        wait_sb_empty("after_invuln_hit", 10);
        check("after_invuln_p2", p2_health, 80);

        // Simultaneous trade.
        do_reset();
        player_2_collision = 1'b1;
        cycles(3);
        push(1, 1, 90, 90);
        press(1, 1);
        wait_sb_empty("trade_hit", 10);
        check("trade_p1", p1_health, 90);
        check("trade_p2", p2_health, 90);

        // Ten P1 hits down to KO, restart ignored mid-round.
        do_reset();
        player_1_collision = 1'b1;
        cycles(3);
        for (int h = 1; h <= 10; h++) begin
            push(0, 1, 100, 100 - 10 * h);
            press(1, 0);
            wait_sb_empty("ko_hit", 10);
            if (h == 1) begin
                restart = 1'b1;
                cycle();
                restart = 1'b0;
                check("restart_ignored", p2_health, 90);
            end
            if (h == 10) begin
                check("ko_not_yet_over", game_over, 0);
                cycle();
                check("ko_game_over", game_over, 1);
            end
            cycles(45);
        end
        check("ko_p2_health", p2_health, 0);
        check("ko_p1_health", p1_health, 100);
        check("ko_winner", winner, 1);
        p1_attack = 1'b1;
        p2_attack = 1'b1;
        cycle();
        check("over_no_attack", {p1_attacking, p2_attacking}, 0);
        p1_attack = 1'b0;
        p2_attack = 1'b0;
        cycles(20);
        check("frozen_p1", p1_health, 100);
        check("frozen_p2", p2_health, 0);
        player_1_collision = 1'b0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        check_fresh("restart");

        // Reset mid-attack and mid-invulnerability.
        do_reset();
        player_2_collision = 1'b1;
        cycles(3);
        push(0, 1, 100, 90);
        p1_attack = 1'b1;
        wait_sb_empty("pre_reset_hit", 10);
        check("pre_reset_active", p1_attacking, 1);
        reset     = 1'b1;
        p1_attack = 1'b0;
        cycle();
        check_fresh("mid_reset");
        reset = 1'b0;
        cycles(3);
        push(0, 1, 100, 90);
        press(1, 0);
        wait_sb_empty("post_reset_hit", 10);
        check("post_reset_p2", p2_health, 90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
